spi_cmd_handler: RTL



---
 rtl/spi_cmd_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/spi_cmd_handler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command handler.
package spi_cmd_pkg;

  localparam logic [7:0] OP_ECHO  = 8'h01;
  localparam logic [7:0] OP_PING  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h10;
  localparam logic [7:0] OP_READ  = 8'h11;

  localparam logic [7:0] RSP_PING = 8'h05;
  localparam logic [7:0] RSP_ACK  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ECHO_B,
    WR_ADDR,
    WR_DATA,
    RD_ADDR
  } parse_state_t;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers and a synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok, push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush empties the FIFO and overrides push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/spi_cmd_handler.sv
// Command parser behind the SPI slave: decodes opcode frames, owns a small
// register file and queues response bytes for the MISO side.
module spi_cmd_handler
  import spi_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned RESP_DEPTH = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'h00,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_req,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       led,
  output logic [7:0] err_count
);

  localparam int unsigned RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  parse_state_t state_q, state_d;
  logic [7:0]   addr_q;
  logic [7:0]   regs_q [NUM_REGS];
  logic [7:0]   err_q;

  logic         push;
  logic [7:0]   push_data;
  logic         proto_err;
  logic         wr_en;
  logic         rx_addr_ok, wr_addr_ok;
  logic [RIW-1:0] rd_idx, wr_idx;

  logic         fifo_full, fifo_empty;
  logic [7:0]   fifo_head;
  logic         pop_ok, drop;

  assign rx_addr_ok = ({24'd0, rx_byte} < NUM_REGS);
  assign wr_addr_ok = ({24'd0, addr_q} < NUM_REGS);
  assign rd_idx     = rx_byte[RIW-1:0];
  assign wr_idx     = addr_q[RIW-1:0];

  // Opcode decode: next parser state, response byte and error flag for this byte.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = IDLE_BYTE;
    proto_err = 1'b0;
    wr_en     = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          case (rx_byte)
            OP_PING: begin
              push      = 1'b1;
              push_data = RSP_PING;
            end
            OP_ECHO:  state_d = ECHO_B;
            OP_WRITE: state_d = WR_ADDR;
            OP_READ:  state_d = RD_ADDR;
            default: begin
              push      = 1'b1;
              push_data = ERR_BYTE;
              proto_err = 1'b1;
            end
          endcase
        end
        ECHO_B: begin
          state_d   = IDLE;
          push      = 1'b1;
          push_data = rx_byte;
        end
        WR_ADDR: state_d = WR_DATA;
        WR_DATA: begin
          state_d   = IDLE;
          push      = 1'b1;
          wr_en     = wr_addr_ok;
          push_data = wr_addr_ok ? RSP_ACK : ERR_BYTE;
          proto_err = ~wr_addr_ok;
        end
        RD_ADDR: begin
          state_d   = IDLE;
          push      = 1'b1;
          push_data = rx_addr_ok ? regs_q[rd_idx] : ERR_BYTE;
          proto_err = ~rx_addr_ok;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Overflow is a push that finds the FIFO full with no same-cycle pop.
  assign pop_ok = tx_req & frame_active & ~fifo_empty;
  assign drop   = push & fifo_full & ~pop_ok;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (~frame_active),
    .push_i      (push & frame_active),
    .push_data_i (push_data),
    .pop_i       (tx_req & frame_active),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Parser state and latched write address; frame end returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else if (!frame_active) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      if (rx_valid && state_q == WR_ADDR) addr_q <= rx_byte;
    end
  end

  // Register file write on the completing data byte of a valid WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (frame_active && wr_en) begin
      regs_q[wr_idx] <= rx_byte;
    end
  end

  // Saturating error counter; simultaneous error sources count once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (frame_active && (proto_err || drop)) begin
      err_q <= sat_inc(err_q);
    end
  end

  assign tx_valid  = ~fifo_empty;
  assign tx_byte   = fifo_empty ? IDLE_BYTE : fifo_head;
  assign led       = regs_q[0][0];
  assign err_count = err_q;

endmodule
